// File: rtl/counter_share_ctrl_pkg.sv
// Shared types and defaults for the time-shared counter controller.
package counter_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

    // Pointer width that stays at least one bit for tiny requester counts.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_share_ctrl_if.sv
// Request/grant/counter bundle between client logic and the shared counter.
interface counter_share_if
    import counter_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] len;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         q;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    modport master (output req, len, input gnt, q, done, busy);
    modport slave  (input req, len, output gnt, q, done, busy);
endinterface

// File: rtl/counter_share_ctrl_rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping.
module rr_pick
    import counter_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      win_idx,
    output logic [NUM_REQ-1:0] win_oh,
    output logic               any_req
);
    logic [NUM_REQ-1:0] rot;
    int unsigned        pos;

    always_comb begin
        // rot[i] is req[(ptr+i) mod NUM_REQ], so the lowest set bit is the winner.
        rot     = NUM_REQ'({req, req} >> ptr);
        win_idx = '0;
        win_oh  = '0;
        any_req = 1'b0;
        pos     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_req && |(rot & (NUM_REQ'(1) << i))) begin
                any_req = 1'b1;
                pos     = 32'(ptr) + i;
                if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                win_idx = PW'(pos);
                win_oh  = NUM_REQ'(1) << pos;
            end
        end
    end
endmodule

// File: rtl/counter_share_ctrl.sv
// Time-shares one up-counter among NUM_REQ requesters with round-robin grants.
module counter_share_ctrl
    import counter_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    counter_share_if.slave bus
);
    localparam int PW = ptr_width(NUM_REQ);

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [PW-1:0]      pick_idx;
    logic [PW-1:0]      next_ptr;
    logic [NUM_REQ-1:0] pick_oh;
    logic               any_req;
    logic               win_req;
    logic [WIDTH-1:0]   tgt;
    logic [WIDTH-1:0]   pick_len;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win_idx (pick_idx),
        .win_oh  (pick_oh),
        .any_req (any_req)
    );

    always_comb begin
        pick_len = WIDTH'(bus.len >> (32'(pick_idx) * WIDTH));
        // gnt is one-hot on the winner, so this is req[win] without a variable index.
        win_req  = |(bus.req & bus.gnt);
        next_ptr = (32'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bus.gnt  <= '0;
            bus.q    <= '0;
            bus.done <= '0;
            bus.busy <= 1'b0;
            ptr      <= '0;
            win      <= '0;
            tgt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        bus.gnt  <= pick_oh;
                        bus.q    <= '0;
                        bus.busy <= 1'b1;
                        win      <= pick_idx;
                        tgt      <= pick_len;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!win_req) begin
                        bus.gnt  <= '0;
                        bus.busy <= 1'b0;
                        ptr      <= next_ptr;
                        state    <= ST_IDLE;
                    end else if (bus.q == tgt) begin
                        bus.done <= bus.gnt;
                        state    <= ST_DONE;
                    end else begin
                        bus.q <= bus.q + WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    bus.done <= '0;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= next_ptr;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.gnt  <= '0;
                    bus.done <= '0;
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_share_ctrl.sv
// Bench for counter_share_ctrl: directed scenarios plus randomized runs against a timeline model.
module tb_counter_share_ctrl;
    import counter_share_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   ptr_m = 0;
    int   lens[N];

    counter_share_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    counter_share_ctrl #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_len;
        for (int i = 0; i < N; i++) bus.len[i*W +: W] = W'(lens[i]);
    endtask

    // Reference arbitration: first requester at or after p, modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (p + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Expected timeline of one grant of length L to requester w, starting just before the grant edge.
    task automatic run_and_check(input int w, input int L, input bit drop, input bit scramble);
        logic [N-1:0] oh;
        oh = '0;
        if (w >= 0) oh[w] = 1'b1;
        for (int k = 1; k <= L + 1; k++) begin
            tick;
            checks++;
            if (bus.gnt !== oh || bus.q !== W'(k - 1) || bus.done !== '0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL run w=%0d k=%0d: gnt=%b q=%0d done=%b busy=%b, expected gnt=%b q=%0d done=0000 busy=1",
                         w, k, bus.gnt, bus.q, bus.done, bus.busy, oh, k - 1);
            end
            if (scramble && k == 1) begin
                for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 15);
                drive_len();
            end
        end
        tick;
        checks++;
        if (bus.gnt !== oh || bus.q !== W'(L) || bus.done !== oh || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse w=%0d L=%0d: gnt=%b q=%0d done=%b busy=%b, expected gnt=%b q=%0d done=%b busy=1",
                     w, L, bus.gnt, bus.q, bus.done, bus.busy, oh, L, oh);
        end
        if (drop && w >= 0) bus.req[w] = 1'b0;
        tick;
        checks++;
        if (bus.gnt !== '0 || bus.q !== W'(L) || bus.done !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL release w=%0d L=%0d: gnt=%b q=%0d done=%b busy=%b, expected gnt=0000 q=%0d done=0000 busy=0",
                     w, L, bus.gnt, bus.q, bus.done, bus.busy, L);
        end
        ptr_m = (w + 1) % N;
    endtask

    task automatic test_reset;
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) lens[i] = 1;
        drive_len();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks++;
            if (bus.gnt !== '0 || bus.q !== '0 || bus.done !== '0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold c=%0d: gnt=%b q=%0d done=%b busy=%b, expected all zero",
                         c, bus.gnt, bus.q, bus.done, bus.busy);
            end
        end
        rst = 1'b0;
        ptr_m = 0;
        run_and_check(pick(bus.req, ptr_m), 1, 1'b1, 1'b0);
        bus.req = '0;
        tick;
    endtask

    task automatic test_single;
        lens[2] = 3;
        drive_len();
        bus.req = 4'b0100;
        run_and_check(pick(bus.req, ptr_m), 3, 1'b1, 1'b0);
        tick;
        checks++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.q !== 4'd3) begin
            failures++;
            $display("FAIL idle_hold: gnt=%b busy=%b q=%0d, expected gnt=0000 busy=0 q=3",
                     bus.gnt, bus.busy, bus.q);
        end
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ptr_m = 0;
        for (int i = 0; i < N; i++) lens[i] = 1;
        drive_len();
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) run_and_check(pick(bus.req, ptr_m), 1, 1'b0, 1'b0);
        bus.req = '0;
        tick;
    endtask

    task automatic test_len_edges;
        lens[1] = 0;
        lens[3] = 15;
        drive_len();
        bus.req = 4'b0010;
        run_and_check(pick(bus.req, ptr_m), 0, 1'b1, 1'b0);
        bus.req = 4'b1000;
        run_and_check(pick(bus.req, ptr_m), 15, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ptr_m = 0;
        lens[0] = 4;
        lens[1] = 8;
        lens[2] = 2;
        drive_len();
        bus.req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (bus.gnt !== 4'b0010 || bus.q !== W'(k)) begin
                failures++;
                $display("FAIL abort_pre k=%0d: gnt=%b q=%0d, expected gnt=0010 q=%0d", k, bus.gnt, bus.q, k);
            end
        end
        bus.req = 4'b0101;
        tick;
        checks++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || bus.q !== 4'd3) begin
            failures++;
            $display("FAIL abort_exit: gnt=%b done=%b busy=%b q=%0d, expected gnt=0000 done=0000 busy=0 q=3",
                     bus.gnt, bus.done, bus.busy, bus.q);
        end
        ptr_m = 2;
        run_and_check(pick(bus.req, ptr_m), 2, 1'b1, 1'b0);
        bus.req = '0;
        tick;
    endtask

    task automatic test_reset_mid_run;
        lens[3] = 9;
        drive_len();
        bus.req = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++;
            if (bus.gnt !== 4'b1000 || bus.q !== W'(k)) begin
                failures++;
                $display("FAIL midrun_pre k=%0d: gnt=%b q=%0d, expected gnt=1000 q=%0d", k, bus.gnt, bus.q, k);
            end
        end
        rst = 1'b1;
        tick;
        checks++;
        if (bus.gnt !== '0 || bus.q !== '0 || bus.done !== '0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: gnt=%b q=%0d done=%b busy=%b, expected all zero",
                     bus.gnt, bus.q, bus.done, bus.busy);
        end
        rst = 1'b0;
        ptr_m = 0;
        lens[0] = 2;
        drive_len();
        bus.req = 4'b1001;
        run_and_check(pick(bus.req, ptr_m), 2, 1'b1, 1'b0);
        bus.req = '0;
        tick;
    endtask

    task automatic test_random;
        for (int it = 0; it < 25; it++) begin
            int w;
            bus.req = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 15);
            drive_len();
            w = pick(bus.req, ptr_m);
            run_and_check(w, lens[w], 1'b1, 1'b1);
        end
        bus.req = '0;
        tick;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.len = '0;
        tick;
        test_reset();
        test_single();
        test_round_robin();
        test_len_edges();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
